// File: rtl/rc4_decrypt_engine.sv
// RC4 decrypt engine: S-box init, key scheduling and keystream decrypt in one FSM.
// Build option CHAR_CHECK_EN: abort on the first decrypted byte outside 'a'..'z' and space.
module rc4_decrypt_engine #(
  parameter int KEY_BYTES = 3,
  parameter int MSG_LEN   = 32,
  parameter int MSG_AW    = 5
) (
  input  logic                   inclk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  output logic                   busy,
  output logic                   done,
  output logic                   key_ok,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  input  logic [7:0]             s_q,
  output logic [MSG_AW-1:0]      enc_addr,
  input  logic [7:0]             enc_q,
  output logic [MSG_AW-1:0]      dec_addr,
  output logic [7:0]             dec_data,
  output logic                   dec_wren
);

  localparam int             KIW       = $clog2(KEY_BYTES + 1);
  localparam logic [7:0]     LAST_K    = 8'(MSG_LEN - 1);
  localparam logic [KIW-1:0] LAST_KIDX = KIW'(KEY_BYTES - 1);

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_INIT,
    ST_KSA_RD_I,
    ST_KSA_WT_I,
    ST_KSA_RD_J,
    ST_KSA_WT_J,
    ST_KSA_WR_I,
    ST_KSA_WR_J,
    ST_PRGA_RD_I,
    ST_PRGA_WT_I,
    ST_PRGA_RD_J,
    ST_PRGA_WT_J,
    ST_PRGA_WR_I,
    ST_PRGA_WR_J,
    ST_PRGA_RD_F,
    ST_PRGA_WT_F,
    ST_PRGA_WR_D,
    ST_DONE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [KEY_BYTES*8-1:0] key_reg;
  logic [7:0]             i;
  logic [7:0]             j;
  logic [7:0]             k;
  logic [7:0]             si;
  logic [7:0]             sj;
  logic [7:0]             dec_byte;
  logic [7:0]             key_byte;
  logic [KIW-1:0]         kidx;
  logic                   char_ok;
  logic                   last_byte;

  // Key byte for the current KSA step; kidx walks 0..KEY_BYTES-1 so no modulo is needed.
  always_comb begin
    // NOTE: key_byte gets a default before the loop so no path leaves it unassigned (no latch).
    key_byte = 8'h00;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx == KIW'(b)) key_byte = key_reg[(KEY_BYTES-1-b)*8 +: 8];
    end
  end

`ifdef CHAR_CHECK_EN
  assign char_ok = ((dec_byte >= 8'h61) && (dec_byte <= 8'h7A)) || (dec_byte == 8'h20);
`else
  assign char_ok = 1'b1;
`endif

  assign last_byte = (k == LAST_K);

  always_ff @(posedge inclk) begin
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge inclk) begin
    if (!reset_n) begin
      // NOTE: only control/datapath registers reset; the external S and dec memories keep contents.
      key_reg  <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      kidx     <= '0;
      si       <= '0;
      sj       <= '0;
      dec_byte <= '0;
      key_ok   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            key_reg <= secret_key;
            key_ok  <= 1'b0;
            i       <= '0;
            j       <= '0;
            k       <= '0;
            kidx    <= '0;
          end
        end
        ST_INIT: i <= i + 8'd1;
        ST_KSA_WT_I: begin
          si <= s_q;
          j  <= j + s_q + key_byte;
        end
        ST_KSA_WT_J, ST_PRGA_WT_J: sj <= s_q;
        ST_KSA_WR_J: begin
          kidx <= (kidx == LAST_KIDX) ? '0 : kidx + 1'b1;
          // PRGA starts with i already advanced to 1 and j cleared
          if (i == 8'hFF) begin
            i <= 8'd1;
            j <= '0;
          end else begin
            i <= i + 8'd1;
          end
        end
        ST_PRGA_WT_I: begin
          si <= s_q;
          j  <= j + s_q;
        end
        ST_PRGA_WT_F: dec_byte <= s_q ^ enc_q;
        ST_PRGA_WR_D: begin
          i <= i + 8'd1;
          k <= k + 8'd1;
          if (last_byte || !char_ok) key_ok <= char_ok;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    s_addr    = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    enc_addr  = '0;
    dec_addr  = '0;
    dec_data  = '0;
    dec_wren  = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        s_addr = i;
        s_data = i;
        s_wren = 1'b1;
        if (i == 8'hFF) state_nxt = ST_KSA_RD_I;
      end
      ST_KSA_RD_I: begin
        s_addr    = i;
        state_nxt = ST_KSA_WT_I;
      end
      ST_KSA_WT_I: state_nxt = ST_KSA_RD_J;
      ST_KSA_RD_J: begin
        s_addr    = j;
        state_nxt = ST_KSA_WT_J;
      end
      ST_KSA_WT_J: state_nxt = ST_KSA_WR_I;
      ST_KSA_WR_I: begin
        s_addr    = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nxt = ST_KSA_WR_J;
      end
      ST_KSA_WR_J: begin
        s_addr    = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nxt = (i == 8'hFF) ? ST_PRGA_RD_I : ST_KSA_RD_I;
      end
      ST_PRGA_RD_I: begin
        s_addr    = i;
        state_nxt = ST_PRGA_WT_I;
      end
      ST_PRGA_WT_I: state_nxt = ST_PRGA_RD_J;
      ST_PRGA_RD_J: begin
        s_addr    = j;
        state_nxt = ST_PRGA_WT_J;
      end
      ST_PRGA_WT_J: state_nxt = ST_PRGA_WR_I;
      ST_PRGA_WR_I: begin
        s_addr    = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nxt = ST_PRGA_WR_J;
      end
      ST_PRGA_WR_J: begin
        s_addr    = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nxt = ST_PRGA_RD_F;
      end
      // After the swap S[i]+S[j] is still si+sj; the ciphertext read overlaps this lookup
      ST_PRGA_RD_F: begin
        s_addr    = si + sj;
        enc_addr  = MSG_AW'(k);
        state_nxt = ST_PRGA_WT_F;
      end
      ST_PRGA_WT_F: state_nxt = ST_PRGA_WR_D;
      ST_PRGA_WR_D: begin
        dec_addr  = MSG_AW'(k);
        dec_data  = dec_byte;
        dec_wren  = 1'b1;
        state_nxt = (last_byte || !char_ok) ? ST_DONE : ST_PRGA_RD_I;
      end
      ST_DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/rc4_decrypt_engine.md
Name: rc4_decrypt_engine

Overview:
Self-contained, parametrised RC4 decryption engine. Executes S-box init, key scheduling (KSA) and keystream decrypt (PRGA) in a single FSM, with a start/done handshake. Drives external S RAM, encrypted-message ROM and decrypted-message RAM. Intended to be instantiated N times by the key-search top level; it replaces the per-task FSMs and the top-level memory-port muxing.

Parameters:
KEY_BYTES, 3, secret key length in bytes (1..16); key byte 0 = secret_key[KEY_BYTES*8-1 -: 8]
MSG_LEN, 32, message length in bytes (1..256)
MSG_AW, 5, message memory address width; MSG_LEN <= 2**MSG_AW

Ports:
inclk  in  1  clock
reset_n  in  1  synchronous active-low reset
start  in  1  begin run; sampled only in IDLE
secret_key  in  KEY_BYTES*8  key; latched on accepted start
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse at end of run
key_ok  out  1  result of last run; valid from done, held until next accepted start
s_addr  out  8  S RAM address
s_data  out  8  S RAM write data
s_wren  out  1  S RAM write enable
s_q  in  8  S RAM read data
enc_addr  out  MSG_AW  encrypted ROM address
enc_q  in  8  ROM read data
dec_addr  out  MSG_AW  decrypted RAM address
dec_data  out  8  decrypted RAM write data
dec_wren  out  1  decrypted RAM write enable

Behaviour:
- Reset: synchronous, active-low, on the inclk edge. Applies mid-run; FSM returns to IDLE. All outputs 0. Memory contents are not cleared.
- All RAM/ROM reads have 1-cycle latency: address driven in cycle N, q sampled in cycle N+1. Write = wren high for exactly one cycle with addr/data valid.
- Internal index registers i, j, k and temporaries are 8-bit; all index arithmetic wraps mod 256.
- IDLE: start=1 -> latch key, clear key_ok, go to INIT. start while busy is ignored.
- INIT: write S[i]=i for i=0..255, one write per cycle (256 cycles), then go to KSA.
- KSA: j=0; for i=0..255: read S[i]; j=j+S[i]+key[i mod KEY_BYTES]; read S[j]; write S[i]=old S[j]; write S[j]=old S[i]. Sub-states: RD_I, WT_I, RD_J, WT_J, WR_I, WR_J. When i==j, both writes store the same value and S stays unchanged.
- PRGA: i=0, j=0; for k=0..MSG_LEN-1:
  - i=i+1; read S[i]; j=j+S[i]; read S[j]; swap as in KSA.
  - read S[(S[i]+S[j]) mod 256] -> f, using the swapped values.
  - read enc[k]; write dec[k]=f^enc[k].
  - Sub-states: RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_F, WT_F, WR_D. The enc read overlaps RD_F.
- DONE: done=1 for one cycle, busy falls in the same cycle, then return to IDLE. key_ok=1 unless an abort occurred.
- Only one memory write per cycle per RAM. s_wren and dec_wren are never both high.
- Run latency from start to done: at most 1 + 256 + 256*6 + MSG_LEN*9 + 2 cycles.

Optional Feature:
CHAR_CHECK_EN
- Defined: each decrypted byte is checked as it is written. Legal bytes are 8'h61..8'h7A and 8'h20. The first illegal byte is still written to dec RAM; the run then aborts straight to DONE with key_ok=0. No further PRGA iterations are performed.
- Undefined: no check; all MSG_LEN bytes are always decrypted and key_ok=1 at done.

Test Plan:
- KEY_BYTES=3, key 24'h4B6579 ("Key"), MSG_LEN=9, ROM=BB F3 16 E8 D9 40 AF 0A D3 -> dec RAM = "Plaintext" (50 6C 61 69 6E 74 65 78 74), one done pulse. Without CHAR_CHECK_EN: key_ok=1. With CHAR_CHECK_EN: only dec[0]=50 written, key_ok=0.
- KEY_BYTES=4, key 32'h57696B69 ("Wiki"), MSG_LEN=5, ROM=10 21 BF 04 20 -> dec = "pedia", key_ok=1 in both builds. After run, S RAM matches golden model.
- INIT check: stop the S RAM model after 256 writes -> S[n]=n for all n, s_addr 0..255 in consecutive cycles.
- start held high for 3 cycles, and re-pulsed mid-run -> exactly one run and one done. busy is continuously high from start+1 until done.
- reset_n=0 for 1 cycle mid-KSA -> next cycle busy=0, s_wren=0, all outputs 0. A new start then completes the "Key" vector correctly.
- Back-to-back runs: start the cycle after done with key "Wiki" -> correct second result. key_ok clears on the second start.
